// File: rtl/skew_matrix_loader.sv
// skew_matrix_loader: zero-fills one operand's bank pair, then writes a row-major
// int8 batch stream into the skewed layout the systolic array reads.
module skew_matrix_loader #(
    parameter int ARRAY_SIZE      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int BATCH           = 3,
    parameter int ADDR_WIDTH      = 10,
    parameter int CLEAR_DEPTH     = ARRAY_SIZE * BATCH + 3
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       sram_wsb0,
    output logic                       sram_wsb1,
    output logic [ADDR_WIDTH-1:0]      sram_waddr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    output logic [3:0]                 sram_bytemask,
    output logic                       busy,
    output logic                       done
);
    localparam int CW    = $clog2(CLEAR_DEPTH);
    localparam int BW    = BATCH > 1 ? $clog2(BATCH) : 1;
    localparam int XW    = $clog2(ARRAY_SIZE);
    localparam int LANES = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [CW-1:0]              clr_q, clr_d;
    logic [BW-1:0]              b_q, b_d;
    logic [XW-1:0]              r_q, r_d, c_q, c_d;
    logic                       wsb0_q, wsb0_d, wsb1_q, wsb1_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]                 mask_q, mask_d;
    logic                       c_last, r_last, b_last;

    assign c_last = c_q == XW'(ARRAY_SIZE - 1);
    assign r_last = r_q == XW'(ARRAY_SIZE - 1);
    assign b_last = b_q == BW'(BATCH - 1);

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        wsb0_d  = 1'b1;
        wsb1_d  = 1'b1;
        waddr_d = '0;
        wdata_d = '0;
        mask_d  = 4'hf;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CLEAR;
                clr_d   = '0;
            end
            S_CLEAR: begin
                wsb0_d  = 1'b0;
                wsb1_d  = 1'b0;
                mask_d  = 4'h0;
                waddr_d = ADDR_WIDTH'(clr_q);
                clr_d   = clr_q + 1'b1;
                if (clr_q == CW'(CLEAR_DEPTH - 1)) begin
                    state_d = S_LOAD;
                    clr_d   = '0;
                    b_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            // Row r lands in bank r/4, lane r%4, shifted right by r%4 addresses.
            S_LOAD: if (in_valid) begin
                wsb0_d  = r_q[2];
                wsb1_d  = ~r_q[2];
                mask_d  = ~(4'b1000 >> r_q[1:0]);
                waddr_d = ADDR_WIDTH'(ARRAY_SIZE * b_q) + ADDR_WIDTH'(c_q) + ADDR_WIDTH'(r_q[1:0]);
                wdata_d = {LANES{in_data}};
                c_d     = c_q + 1'b1;
                if (c_last) begin
                    r_d = r_q + 1'b1;
                    if (r_last) begin
                        b_d = b_last ? '0 : b_q + 1'b1;
                        if (b_last) state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q <= S_IDLE;
            clr_q   <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            wsb0_q  <= 1'b1;
            wsb1_q  <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
            mask_q  <= 4'hf;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            wsb0_q  <= wsb0_d;
            wsb1_q  <= wsb1_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    assign sram_wsb0     = wsb0_q;
    assign sram_wsb1     = wsb1_q;
    assign sram_waddr    = waddr_q;
    assign sram_wdata    = wdata_q;
    assign sram_bytemask = mask_q;
    assign in_ready      = state_q == S_LOAD;
    assign busy          = state_q == S_CLEAR || state_q == S_LOAD || state_q == S_FLUSH;
    assign done          = state_q == S_DONE;
endmodule

// File: tb/tb_skew_matrix_loader.sv
// tb_skew_matrix_loader: directed bench with a byte-lane SRAM model of both banks.
module tb_skew_matrix_loader;
    logic        clk = 1'b0;
    logic        srst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, sram_wsb0, sram_wsb1, busy, done;
    logic [9:0]  sram_waddr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_bytemask;
    int          total = 0, bad = 0, cyc = 0, dual = 0, oob = 0, t0, v;
    logic [7:0]  el [192];
    logic [31:0] bank0 [0:31] = '{default: 32'hDEADBEEF};
    logic [31:0] bank1 [0:31] = '{default: 32'hDEADBEEF};

    skew_matrix_loader dut (
        .clk(clk), .srst(srst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sram_wsb0(sram_wsb0), .sram_wsb1(sram_wsb1),
        .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_bytemask(sram_bytemask),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_wsb0 || !sram_wsb1) begin
            if (sram_waddr > 10'd26) oob <= oob + 1;
            if (!sram_wsb0 && !sram_wsb1 && sram_bytemask != 4'h0) dual <= dual + 1;
            for (int l = 0; l < 4; l++)
                if (!sram_bytemask[l]) begin
                    if (!sram_wsb0) bank0[sram_waddr[4:0]][8*l+:8] <= sram_wdata[8*l+:8];
                    if (!sram_wsb1) bank1[sram_waddr[4:0]][8*l+:8] <= sram_wdata[8*l+:8];
                end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(output int ts);
        start = 1'b1;
        tick();
        start = 1'b0;
        ts = cyc;
        chk("clr_enter", {busy, in_ready, sram_wsb0, sram_wsb1}, 4'b1011);
        for (int k = 0; k < 27; k++) begin
            start = (k == 10);
            tick();
            start = 1'b0;
            chk($sformatf("clr_%0d", k),
                {in_ready, sram_wsb0, sram_wsb1, sram_bytemask, sram_waddr, sram_wdata},
                {(k == 26), 2'b00, 4'h0, 10'(k), 32'h0});
        end
    endtask

    task automatic stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
                chk("gap_nowrite", {sram_wsb0, sram_wsb1}, 2'b11);
            end
            in_valid = 1'b1;
            in_data  = el[i];
            start    = (i == 100);
            chk("ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (i == 0)
                chk("first", {sram_wsb0, sram_wsb1, sram_bytemask, sram_waddr, sram_wdata},
                    {2'b01, 4'b0111, 10'd0, {4{el[i]}}});
            if (i == 106)
                chk("b1r5c2", {sram_wsb0, sram_wsb1, sram_bytemask, sram_waddr, sram_wdata},
                    {2'b10, 4'b1011, 10'd11, {4{el[i]}}});
            if (i == 191)
                chk("last", {in_ready, busy, sram_wsb0, sram_wsb1, sram_bytemask, sram_waddr, sram_wdata},
                    {4'b0110, 4'b1110, 10'd26, {4{el[i]}}});
        end
    endtask

    task automatic chk_image;
        logic [31:0] e0 [27];
        logic [31:0] e1 [27];
        int a;
        for (int k = 0; k < 27; k++) begin
            e0[k] = '0;
            e1[k] = '0;
        end
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    a = b * 8 + c + r % 4;
                    if (r < 4) e0[a][8*(3-r%4)+:8] = el[b*64+r*8+c];
                    else       e1[a][8*(3-r%4)+:8] = el[b*64+r*8+c];
                end
        for (int k = 0; k < 27; k++) begin
            chk($sformatf("bank0_%0d", k), bank0[k], e0[k]);
            chk($sformatf("bank1_%0d", k), bank1[k], e1[k]);
        end
        chk("pad_b0a0", bank0[0][23:0], 0);
        chk("pad_b1a26", bank1[26][31:8], 0);
        chk("dual_bank", dual, 0);
        chk("addr_range", oob, 0);
    endtask

    initial begin
        srst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h0;
        repeat (2) tick();
        chk("reset", {sram_wsb0, sram_wsb1, sram_bytemask, sram_waddr, sram_wdata, in_ready, busy, done},
            {2'b11, 4'hf, 10'd0, 32'd0, 3'b000});
        srst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        chk("idle_ignores_valid", {in_ready, busy, sram_wsb0, sram_wsb1}, 4'b0011);
        in_valid = 1'b0;

        for (int i = 0; i < 192; i++) el[i] = 8'($urandom);
        el[0] = 8'h12;
        el[106] = 8'h80;
        do_clear(t0);
        stream(192, 1'b1);
        tick();
        chk("done_pulse", {done, busy, sram_wsb0, sram_wsb1}, 4'b1011);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_once", {done, busy}, 2'b00);
        tick();
        chk("start_in_done_ignored", {busy, sram_wsb0, sram_wsb1}, 3'b011);
        chk_image();
        v = $signed(bank1[11][23:16]);
        chk("neg128", v, -128);

        for (int i = 0; i < 192; i++) el[i] = 8'($urandom);
        do_clear(t0);
        stream(50, 1'b1);
        #1;
        srst = 1'b1;
        #1;
        chk("async_rst", {sram_wsb0, sram_wsb1, in_ready, busy, sram_bytemask}, {4'b1100, 4'hf});
        tick();
        srst = 1'b0;

        for (int i = 0; i < 192; i++) el[i] = 8'($urandom);
        do_clear(t0);
        stream(192, 1'b0);
        tick();
        chk("done_after_reload", {done, busy}, 2'b10);
        chk("load_latency", cyc - t0 + 1, 221);
        tick();
        chk_image();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
